// File: rtl/btn_event_queue_pkg.sv
// Shared definitions for the button event queue: channel indices and event record layout.
package btn_event_queue_pkg;

  typedef enum logic [2:0] {
    BTN_U = 3'd0,
    BTN_D = 3'd1,
    BTN_L = 3'd2,
    BTN_R = 3'd3,
    BTN_M = 3'd4
  } btn_idx_e;

  function automatic int code_w(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

  // Event record is packed as {release, code, time}, MSB first.
  function automatic int ev_rec_w(input int n_btn, input int ts_w);
    return 1 + code_w(n_btn) + ts_w;
  endfunction

endpackage

// File: rtl/btn_event_queue_if.sv
// Valid/ready event stream between the button queue (master) and its consumer (slave).
interface btn_event_queue_if #(
  parameter int CODE_W = 3,
  parameter int TS_W   = 16
);
  logic              ev_valid;
  logic              ev_ready;
  logic [CODE_W-1:0] ev_code;
  logic              ev_release;
  logic [TS_W-1:0]   ev_time;

  modport master (output ev_valid, ev_code, ev_release, ev_time, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_release, ev_time, output ev_ready);
endinterface

// File: rtl/btn_event_queue_debounce.sv
// One button channel: 2-FF synchroniser, stable-count debouncer, registered rise/fall pulses.
module btn_event_queue_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
)(
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        rise_q  <= sync_q[1];
        fall_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/btn_event_queue.sv
// Debounced, timestamped button event queue with valid/ready drain.
// Define RELEASE_EVENT_EN to also queue release edges (ev_release=1).
module btn_event_queue
  import btn_event_queue_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 8,
  parameter int TS_W            = 16,
  parameter int TICK_DIV        = 100000
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BTN-1:0]     btn_raw_i,
  input  logic                 clear_i,
  output logic [N_BTN-1:0]     btn_level_o,
  output logic                 overflow_o,
  btn_event_queue_if.master    ev
);
  localparam int CODE_W = code_w(N_BTN);
  localparam int REC_W  = ev_rec_w(N_BTN, TS_W);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [N_BTN-1:0] rise, fall;

  for (genvar g = 0; g < N_BTN; g++) begin : g_db
    btn_event_queue_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (btn_raw_i[g]),
      .level_o (btn_level_o[g]),
      .rise_o  (rise[g]),
      .fall_o  (fall[g])
    );
  end

  // Free-running timestamp advanced once per TICK_DIV cycles.
  logic [PS_W-1:0] ps_q;
  logic [TS_W-1:0] ts_q;
  logic            tick;
  assign tick = (ps_q == PS_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= '0;
      ts_q <= '0;
    end else begin
      ps_q <= tick ? '0 : ps_q + PS_W'(1);
      if (tick) ts_q <= ts_q + TS_W'(1);
    end
  end

  logic [N_BTN-1:0]           pend_p_q;
  logic [N_BTN-1:0][TS_W-1:0] stamp_p_q;
`ifdef RELEASE_EVENT_EN
  logic [N_BTN-1:0]           pend_r_q;
  logic [N_BTN-1:0][TS_W-1:0] stamp_r_q;
`else
  logic unused_fall;
  assign unused_fall = ^fall;
`endif

  // Lowest channel wins; within a channel the press outranks the release.
  logic              win_vld, win_rel;
  logic [CODE_W-1:0] win_code;
  logic [TS_W-1:0]   win_ts;

  always_comb begin
    win_vld  = 1'b0;
    win_rel  = 1'b0;
    win_code = '0;
    win_ts   = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
`ifdef RELEASE_EVENT_EN
      if (pend_r_q[i]) begin
        win_vld  = 1'b1;
        win_rel  = 1'b1;
        win_code = CODE_W'(i);
        win_ts   = stamp_r_q[i];
      end
`endif
      if (pend_p_q[i]) begin
        win_vld  = 1'b1;
        win_rel  = 1'b0;
        win_code = CODE_W'(i);
        win_ts   = stamp_p_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_p_q  <= '0;
      stamp_p_q <= '0;
    end else if (clear_i) begin
      pend_p_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (rise[i]) begin
          pend_p_q[i]  <= 1'b1;
          stamp_p_q[i] <= ts_q;
        end else if (win_vld && !win_rel && win_code == CODE_W'(i)) begin
          pend_p_q[i] <= 1'b0;
        end
      end
    end
  end

`ifdef RELEASE_EVENT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r_q  <= '0;
      stamp_r_q <= '0;
    end else if (clear_i) begin
      pend_r_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (fall[i]) begin
          pend_r_q[i]  <= 1'b1;
          stamp_r_q[i] <= ts_q;
        end else if (win_vld && win_rel && win_code == CODE_W'(i)) begin
          pend_r_q[i] <= 1'b0;
        end
      end
    end
  end
`endif

  // Event FIFO; the winner is always consumed, so a full queue without a pop drops it.
  logic [FIFO_DEPTH-1:0][REC_W-1:0] mem_q;
  logic [PTR_W-1:0]                 wr_q, rd_q;
  logic [PTR_W:0]                   cnt_q;
  logic                             overflow_q;
  logic                             full, pop, push;

  assign full = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pop  = (cnt_q != '0) && ev.ev_ready;
  assign push = win_vld && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {win_rel, win_code, win_ts};
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (win_vld && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign ev.ev_valid = (cnt_q != '0);
  assign {ev.ev_release, ev.ev_code, ev.ev_time} = mem_q[rd_q];
  assign overflow_o  = overflow_q;
endmodule

// File: tb/tb_btn_event_queue.sv
// Bench for btn_event_queue: directed table, corner sequences and random stimulus vs a reference model.
module tb_btn_event_queue;
  import btn_event_queue_pkg::*;

  localparam int N_BTN  = 5;
  localparam int DEB    = 4;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 8;
  localparam int CODE_W = 3;
`ifdef RELEASE_EVENT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic [N_BTN-1:0] raw = '0;
  logic [N_BTN-1:0] level;
  logic             ovf;

  btn_event_queue_if #(.CODE_W(CODE_W), .TS_W(TS_W)) evif();

  btn_event_queue #(
    .N_BTN(N_BTN), .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .TS_W(TS_W), .TICK_DIV(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw_i(raw), .clear_i(clear),
    .btn_level_o(level), .overflow_o(ovf), .ev(evif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: event-level view driven by the raw sample history.
  typedef struct packed {
    logic              rel;
    logic [CODE_W-1:0] code;
    logic [TS_W-1:0]   t;
  } ev_t;

  ev_t                        mq[$];
  logic [N_BTN-1:0]           hist[$];
  logic [N_BTN-1:0]           m_lvl, m_pp, m_pr, m_rise, m_fall;
  logic [N_BTN-1:0][TS_W-1:0] m_tp, m_tr;
  logic                       m_ovf;
  int                         n;

  task automatic model_reset();
    mq.delete();
    hist.delete();
    m_lvl = '0; m_pp = '0; m_pr = '0; m_rise = '0; m_fall = '0;
    m_tp = '0; m_tr = '0; m_ovf = 1'b0; n = 0;
  endtask

  task automatic model_edge(input logic [N_BTN-1:0] r, input logic c, input logic rdy);
    bit pop, found, frel, tog;
    int fidx;
    logic [N_BTN-1:0] s;
    ev_t w;
    n++;
    pop = (mq.size() != 0) && rdy;
    found = 1'b0; frel = 1'b0; fidx = 0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!found && m_pp[i]) begin found = 1'b1; fidx = i; frel = 1'b0; end
      else if (!found && REL_EN && m_pr[i]) begin found = 1'b1; fidx = i; frel = 1'b1; end
    end
    w.rel  = frel;
    w.code = CODE_W'(fidx);
    w.t    = frel ? m_tr[fidx] : m_tp[fidx];
    if (c) begin
      mq.delete(); m_ovf = 1'b0; m_pp = '0; m_pr = '0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (found) begin
        if (mq.size() < DEPTH) mq.push_back(w);
        else m_ovf = 1'b1;
        if (frel) m_pr[fidx] = 1'b0;
        else      m_pp[fidx] = 1'b0;
      end
      for (int i = 0; i < N_BTN; i++) begin
        if (m_rise[i]) begin m_pp[i] = 1'b1; m_tp[i] = TS_W'(n - 1); end
        if (REL_EN && m_fall[i]) begin m_pr[i] = 1'b1; m_tr[i] = TS_W'(n - 1); end
      end
    end
    // Level flips once the DEB most recent synchronised samples all disagree with it.
    for (int i = 0; i < N_BTN; i++) begin
      tog = 1'b1;
      for (int k = n - DEB - 1; k <= n - 2; k++) begin
        s = (k < 1) ? '0 : hist[k-1];
        if (s[i] == m_lvl[i]) tog = 1'b0;
      end
      m_rise[i] = tog && !m_lvl[i];
      m_fall[i] = tog && m_lvl[i];
      if (tog) m_lvl[i] = !m_lvl[i];
    end
    hist.push_back(r);
  endtask

  task automatic compare_all();
    chk("ev_valid", evif.ev_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("ev_code", evif.ev_code, mq[0].code);
      chk("ev_release", evif.ev_release, mq[0].rel);
      chk("ev_time", evif.ev_time, mq[0].t);
    end
    chk("overflow", ovf, m_ovf);
    chk("btn_level", level, m_lvl);
  endtask

  task automatic cycle(input logic [N_BTN-1:0] r, input logic c, input logic rdy);
    raw = r; clear = c; evif.ev_ready = rdy;
    @(posedge clk);
    model_edge(r, c, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic settle();
    repeat (12) cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_valid"}, evif.ev_valid, 1'b0);
    chk({tag, "_ovf"}, ovf, 1'b0);
    chk({tag, "_level"}, level, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N_BTN-1:0]  raw;
    int                hold;
    logic [N_BTN-1:0]  lvl;
    logic              vld;
    logic [CODE_W-1:0] code;
    logic              ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, nev;
    logic [CODE_W-1:0] c0;
    logic [TS_W-1:0] t0;
    logic [N_BTN-1:0] r;
    bit seen;

    vecs[0] = '{5'b00100, 20, 5'b00100, 1'b1, CODE_W'(BTN_L), 1'b0};
    vecs[1] = '{5'b00010,  3, 5'b00000, 1'b0, '0,             1'b0};
    vecs[2] = '{5'b10000,  5, 5'b00000, 1'b0, '0,             1'b0};
    vecs[3] = '{5'b10000,  6, 5'b10000, 1'b0, '0,             1'b0};
    vecs[4] = '{5'b10000,  8, 5'b10000, 1'b1, CODE_W'(BTN_M), 1'b0};
    vecs[5] = '{5'b01001, 20, 5'b01001, 1'b1, CODE_W'(BTN_U), 1'b0};
    vecs[6] = '{5'b11111, 20, 5'b11111, 1'b1, CODE_W'(BTN_U), 1'b1};

    evif.ev_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", evif.ev_valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_level", level, '0);
    chk("rst_code", evif.ev_code, '0);
    chk("rst_time", evif.ev_time, '0);
    rst_n = 1'b1;

    // Isolated press: latency and a single event.
    lat = -1; nev = 0; c0 = '1;
    for (int c = 1; c <= 20; c++) begin
      cycle(5'b00100, 1'b0, 1'b1);
      if (evif.ev_valid) begin
        if (lat < 0) lat = c;
        nev++;
        c0 = evif.ev_code;
      end
    end
    chk("t1_latency", lat, 8);
    chk("t1_events", nev, 1);
    chk("t1_code", c0, BTN_L);

    for (int v = 0; v < 7; v++) begin
      settle();
      for (int c = 0; c < vecs[v].hold; c++) cycle(vecs[v].raw, 1'b0, 1'b0);
      chk($sformatf("vec%0d_level", v), level, vecs[v].lvl);
      chk($sformatf("vec%0d_valid", v), evif.ev_valid, vecs[v].vld);
      if (vecs[v].vld) chk($sformatf("vec%0d_code", v), evif.ev_code, vecs[v].code);
      chk($sformatf("vec%0d_ovf", v), ovf, vecs[v].ovf);
    end

    // Overflowed queue drains in channel order.
    for (int k = 1; k <= 3; k++) begin
      cycle(5'b11111, 1'b0, 1'b1);
      chk($sformatf("t4_drain%0d", k), evif.ev_code, k);
    end
    cycle(5'b11111, 1'b0, 1'b1);
    chk("t4_empty", evif.ev_valid, 1'b0);
    chk("t4_ovf_sticky", ovf, 1'b1);

    // Clear flushes queue and overflow but keeps debounced levels.
    repeat (10) cycle('0, 1'b0, 1'b0);
    repeat (20) cycle(5'b01001, 1'b0, 1'b0);
    chk("t5_pre_valid", evif.ev_valid, 1'b1);
    chk("t5_pre_ovf", ovf, 1'b1);
    cycle(5'b01001, 1'b1, 1'b0);
    chk("t5_valid", evif.ev_valid, 1'b0);
    chk("t5_ovf", ovf, 1'b0);
    chk("t5_level", level, 5'b01001);

    // Simultaneous presses: consecutive events with equal timestamps.
    settle();
    seen = 1'b0; t0 = '0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle(5'b01001, 1'b0, 1'b1);
      if (evif.ev_valid) begin
        seen = 1'b1;
        t0 = evif.ev_time;
        chk("t3_first_code", evif.ev_code, BTN_U);
      end
    end
    chk("t3_seen", seen, 1'b1);
    cycle(5'b01001, 1'b0, 1'b1);
    chk("t3_second_valid", evif.ev_valid, 1'b1);
    chk("t3_second_code", evif.ev_code, BTN_R);
    chk("t3_same_time", evif.ev_time, t0);

`ifdef RELEASE_EVENT_EN
    settle();
    repeat (20) cycle(5'b10000, 1'b0, 1'b0);
    repeat (20) cycle('0, 1'b0, 1'b0);
    chk("t6_press_code", evif.ev_code, BTN_M);
    chk("t6_press_rel", evif.ev_release, 1'b0);
    t0 = evif.ev_time;
    cycle('0, 1'b0, 1'b1);
    chk("t6_rel_code", evif.ev_code, BTN_M);
    chk("t6_rel_rel", evif.ev_release, 1'b1);
    chk("t6_dt", TS_W'(evif.ev_time - t0), 20);
`endif

    // Asynchronous reset with events queued.
    settle();
    repeat (20) cycle(5'b01001, 1'b0, 1'b0);
    chk("t7_pre_valid", evif.ev_valid, 1'b1);
    async_reset_check("t7_arst");

    // Random stimulus against the model, crossing several timestamp wraps.
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N_BTN; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      if (c == 1500) async_reset_check("rnd_arst");
      cycle(r, $urandom_range(99) == 0,
            ((c / 200) % 2 == 1) ? ($urandom_range(9) == 0) : ($urandom_range(3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
